alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one `alu` instance between two requesters.
  - Requester 0: main execute stage.
  - Requester 1: secondary client, e.g. address-generation or debug unit.
- Each requester uses a valid/ready handshake.
- Grants are round-robin or fixed-priority with a starvation guard.
- Results are registered in one output stage carrying the winner's ID, with ready-based backpressure.
- Sits between the issue logic and writeback; owns the only ALU datapath instance.

Parameters:
- PRIORITY_MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority to requester 0.
- MAX_WAIT, 4, fixed mode only: consecutive lost arbitrations after which requester 1 is forced to win (1..15).
- CNT_WIDTH, 4, width of the starvation counter; must hold MAX_WAIT.

Ports:
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- req0_valid_i / req1_valid_i  in  1  request k valid
- req0_ready_o / req1_ready_o  out  1  request k accepted this cycle
- req0_operand_a_i / req1_operand_a_i  in  WORD_WIDTH  operand A of request k
- req0_operand_b_i / req1_operand_b_i  in  WORD_WIDTH  operand B of request k
- req0_operator_i / req1_operator_i  in  ALU_OP_WIDTH  ALU operation of request k
- result_valid_o  out  1  output stage holds a result
- result_ready_i  in  1  consumer takes result this cycle
- result_o  out  WORD_WIDTH  registered ALU result
- result_id_o  out  1  requester that owns result_o
- stall_cnt_o  out  CNT_WIDTH  current starvation count, for debug/perf

Behaviour:
- Reset (rst_n = 0 at clk edge):
  - result_valid_o = 0, result_o = 0, result_id_o = 0, stall_cnt_o = 0.
  - Round-robin pointer last_grant = 1, so requester 0 wins first.
  - Any in-flight result is discarded; a reset mid-handshake yields no result.
- Stage acceptance: accept = !result_valid_o || result_ready_i. A grant is issued only when accept = 1.
- Grant and ready:
  - grant[k] is combinational from the valids, the policy state and accept.
  - reqk_ready_o = grant[k]. At most one ready is high per cycle.
  - Requesters must not make valid depend on ready.
  - A request must hold its valid and payload stable until ready.
- Round-robin (PRIORITY_MODE = 0):
  - Only one valid: that requester wins.
  - Both valid: the requester != last_grant wins.
  - last_grant updates on every grant.
- Fixed priority (PRIORITY_MODE = 1):
  - Requester 0 wins when valid, unless stall_cnt == MAX_WAIT; then requester 1 wins.
  - stall_cnt increments each cycle that req1_valid_i = 1, accept = 1 and requester 1 is not granted.
  - stall_cnt clears when requester 1 is granted.
  - stall_cnt holds when accept = 0 and when req1_valid_i = 0.
  - stall_cnt is never read past MAX_WAIT.
- Datapath:
  - The winner's operands and operator are muxed into the single `alu`.
  - On a grant edge: result_o <= ALU result, result_id_o <= winner, result_valid_o <= 1.
- Latency: exactly 1 cycle from handshake to result_valid_o.
- Pipelined throughput: result_ready_i = 1 with a new grant in the same cycle gives back-to-back results, one per cycle.
- Drain: result_ready_i = 1 with no grant clears result_valid_o to 0.
- Backpressure: while result_valid_o = 1 and result_ready_i = 0:
  - result_o and result_id_o hold stable.
  - Both readys are 0.
  - Policy state holds.
- Operator width and encodings come from the package. Unknown operators pass the ALU default value through unchanged; the arbiter raises no error.

Decomposition:
- Shared package riscv_defines holds:
  - WORD_WIDTH and ALU_OP_WIDTH;
  - the ALU_* operator encodings;
  - a requester-ID typedef (1 bit) and the PRIORITY_MODE encodings.
- The arbiter instantiates the existing `alu` as its sole sub-module.
- Grant logic stays inline.

Test Plan:
- Single request: req0 ALU_ADD, a=5, b=7, result_ready_i=1 → req0_ready_o high that cycle; next cycle result_valid_o=1, result_o=12, result_id_o=0.
- Round-robin contention: both valid continuously (req0 ALU_SUB 10-3, req1 ALU_XOR 0xF0^0xFF), result_ready_i=1 → result_id_o sequence 0,1,0,1; result_o values 7, 0x0F alternating.
- Backpressure: hold result_ready_i=0 for 3 cycles with result_valid_o=1 → both readys 0, result_o stable; release → result consumed and next grant in the same cycle.
- Fixed priority, MAX_WAIT=3, both valid continuously → result_id_o 0,0,0,1,0,0,0,1; stall_cnt_o 1,2,3,0,….
- Compare ops via req1: ALU_SLT a=0xFFFFFFFF, b=1 → result_o=1; ALU_SLTU same operands → result_o=0.
- Reset mid-operation: drive rst_n=0 for one edge while result_valid_o=1 and stall_cnt_o=2 → next cycle result_valid_o=0, stall_cnt_o=0; with both valid after reset, requester 0 is granted first.

Source files
------------

// File: rtl/riscv_defines.sv
// Shared core definitions: datapath widths, ALU operator encodings,
// requester ID type and arbitration policy encodings.
package riscv_defines;

    localparam int WORD_WIDTH   = 32;
    localparam int ALU_OP_WIDTH = 4;

    typedef logic [ALU_OP_WIDTH-1:0] alu_op_t;

    // Operators are plain constants rather than an enum so that
    // unassigned encodings can travel through the datapath untouched.
    localparam alu_op_t ALU_ADD  = 4'h0;
    localparam alu_op_t ALU_SUB  = 4'h1;
    localparam alu_op_t ALU_XOR  = 4'h2;
    localparam alu_op_t ALU_OR   = 4'h3;
    localparam alu_op_t ALU_AND  = 4'h4;
    localparam alu_op_t ALU_SLL  = 4'h5;
    localparam alu_op_t ALU_SRL  = 4'h6;
    localparam alu_op_t ALU_SRA  = 4'h7;
    localparam alu_op_t ALU_SLT  = 4'h8;
    localparam alu_op_t ALU_SLTU = 4'h9;

    // Value produced for encodings the ALU does not implement.
    localparam logic [WORD_WIDTH-1:0] ALU_DEFAULT = '0;

    typedef logic req_id_t;

    localparam int PRIO_ROUND_ROBIN = 0;
    localparam int PRIO_FIXED       = 1;

    typedef struct packed {
        logic [WORD_WIDTH-1:0] operand_a;
        logic [WORD_WIDTH-1:0] operand_b;
        alu_op_t               operator;
    } alu_req_t;

endpackage

// File: rtl/alu.sv
// Single-cycle combinational integer ALU shared by the execute stage
// and secondary clients.
module alu
    import riscv_defines::*;
(
    input  alu_op_t               operator_i,
    input  logic [WORD_WIDTH-1:0] operand_a_i,
    input  logic [WORD_WIDTH-1:0] operand_b_i,
    output logic [WORD_WIDTH-1:0] result_o
);

    logic [4:0] shamt;
    assign shamt = operand_b_i[4:0];

    // Operation select; unknown encodings yield ALU_DEFAULT.
    always_comb begin
        result_o = ALU_DEFAULT;
        case (operator_i)
            ALU_ADD:  result_o = operand_a_i + operand_b_i;
            ALU_SUB:  result_o = operand_a_i - operand_b_i;
            ALU_XOR:  result_o = operand_a_i ^ operand_b_i;
            ALU_OR:   result_o = operand_a_i | operand_b_i;
            ALU_AND:  result_o = operand_a_i & operand_b_i;
            ALU_SLL:  result_o = operand_a_i << shamt;
            ALU_SRL:  result_o = operand_a_i >> shamt;
            ALU_SRA:  result_o = $unsigned($signed(operand_a_i) >>> shamt);
            ALU_SLT:  result_o = {{(WORD_WIDTH-1){1'b0}},
                                  ($signed(operand_a_i) < $signed(operand_b_i))};
            ALU_SLTU: result_o = {{(WORD_WIDTH-1){1'b0}}, (operand_a_i < operand_b_i)};
            default:  result_o = ALU_DEFAULT;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of the single ALU instance. Round-robin
// or fixed priority with a starvation guard for requester 1; one
// registered result stage with ready-based backpressure.
module alu_arbiter
    import riscv_defines::*;
#(
    parameter int PRIORITY_MODE = PRIO_ROUND_ROBIN,
    parameter int MAX_WAIT      = 4,
    parameter int CNT_WIDTH     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req0_valid_i,
    output logic                  req0_ready_o,
    input  logic [WORD_WIDTH-1:0] req0_operand_a_i,
    input  logic [WORD_WIDTH-1:0] req0_operand_b_i,
    input  alu_op_t               req0_operator_i,

    input  logic                  req1_valid_i,
    output logic                  req1_ready_o,
    input  logic [WORD_WIDTH-1:0] req1_operand_a_i,
    input  logic [WORD_WIDTH-1:0] req1_operand_b_i,
    input  alu_op_t               req1_operator_i,

    output logic                  result_valid_o,
    input  logic                  result_ready_i,
    output logic [WORD_WIDTH-1:0] result_o,
    output req_id_t               result_id_o,
    output logic [CNT_WIDTH-1:0]  stall_cnt_o
);

    localparam logic [CNT_WIDTH-1:0] MAX_WAIT_C = CNT_WIDTH'(MAX_WAIT);

    alu_req_t              req0, req1, alu_req;
    logic [WORD_WIDTH-1:0] alu_result;
    logic                  accept;
    logic [1:0]            grant;
    req_id_t               winner;
    req_id_t               last_grant;
    logic [CNT_WIDTH-1:0]  stall_cnt;

    assign req0 = '{operand_a: req0_operand_a_i, operand_b: req0_operand_b_i,
                    operator: req0_operator_i};
    assign req1 = '{operand_a: req1_operand_a_i, operand_b: req1_operand_b_i,
                    operator: req1_operator_i};

    // The output stage can take a new result when empty or being drained.
    assign accept = !result_valid_o || result_ready_i;

    // Grant selection: only ever one winner, and only when the stage can accept.
    always_comb begin
        grant = 2'b00;
        if (accept) begin
            if (PRIORITY_MODE == PRIO_FIXED) begin
                if (req1_valid_i && (!req0_valid_i || stall_cnt == MAX_WAIT_C))
                    grant = 2'b10;
                else if (req0_valid_i)
                    grant = 2'b01;
            end else begin
                if (req0_valid_i && req1_valid_i)
                    grant = (last_grant == 1'b1) ? 2'b01 : 2'b10;
                else if (req0_valid_i)
                    grant = 2'b01;
                else if (req1_valid_i)
                    grant = 2'b10;
            end
        end
    end

    assign req0_ready_o = grant[0];
    assign req1_ready_o = grant[1];
    assign winner       = grant[1];
    assign alu_req      = grant[1] ? req1 : req0;

    alu u_alu (
        .operator_i  (alu_req.operator),
        .operand_a_i (alu_req.operand_a),
        .operand_b_i (alu_req.operand_b),
        .result_o    (alu_result)
    );

    // Result stage, round-robin pointer and starvation counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_valid_o <= 1'b0;
            result_o       <= '0;
            result_id_o    <= 1'b0;
            last_grant     <= 1'b1;
            stall_cnt      <= '0;
        end else begin
            if (accept) begin
                result_valid_o <= |grant;
                if (|grant) begin
                    result_o    <= alu_result;
                    result_id_o <= winner;
                    last_grant  <= winner;
                end
            end
            if (grant[1])
                stall_cnt <= '0;
            else if (accept && req1_valid_i && stall_cnt != MAX_WAIT_C)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench: one round-robin instance (r_*) and one fixed-priority
// instance with MAX_WAIT=3 (f_*), sharing clock and reset.
module tb_alu_arbiter;
    import riscv_defines::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic                  r_v0 = 0, r_v1 = 0, r_rdy0, r_rdy1, r_rvalid, r_rready = 1;
    logic [WORD_WIDTH-1:0] r_a0 = 0, r_b0 = 0, r_a1 = 0, r_b1 = 0, r_res;
    alu_op_t               r_op0 = ALU_ADD, r_op1 = ALU_ADD;
    req_id_t               r_id;
    logic [3:0]            r_stall;

    logic                  f_v0 = 0, f_v1 = 0, f_rdy0, f_rdy1, f_rvalid, f_rready = 1;
    logic [WORD_WIDTH-1:0] f_a0 = 0, f_b0 = 0, f_a1 = 0, f_b1 = 0, f_res;
    alu_op_t               f_op0 = ALU_ADD, f_op1 = ALU_ADD;
    req_id_t               f_id;
    logic [3:0]            f_stall;

    alu_arbiter #(.PRIORITY_MODE(0), .MAX_WAIT(4), .CNT_WIDTH(4)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .req0_valid_i(r_v0), .req0_ready_o(r_rdy0), .req0_operand_a_i(r_a0),
        .req0_operand_b_i(r_b0), .req0_operator_i(r_op0),
        .req1_valid_i(r_v1), .req1_ready_o(r_rdy1), .req1_operand_a_i(r_a1),
        .req1_operand_b_i(r_b1), .req1_operator_i(r_op1),
        .result_valid_o(r_rvalid), .result_ready_i(r_rready), .result_o(r_res),
        .result_id_o(r_id), .stall_cnt_o(r_stall)
    );

    alu_arbiter #(.PRIORITY_MODE(1), .MAX_WAIT(3), .CNT_WIDTH(4)) u_fx (
        .clk(clk), .rst_n(rst_n),
        .req0_valid_i(f_v0), .req0_ready_o(f_rdy0), .req0_operand_a_i(f_a0),
        .req0_operand_b_i(f_b0), .req0_operator_i(f_op0),
        .req1_valid_i(f_v1), .req1_ready_o(f_rdy1), .req1_operand_a_i(f_a1),
        .req1_operand_b_i(f_b1), .req1_operator_i(f_op1),
        .result_valid_o(f_rvalid), .result_ready_i(f_rready), .result_o(f_res),
        .result_id_o(f_id), .stall_cnt_o(f_stall)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        total++; if (r_rvalid !== 1'b0) $display("FAIL rst_rr_valid got=%0b exp=0", r_rvalid); else passed++;
        total++; if (r_res !== 32'd0) $display("FAIL rst_rr_result got=%0h exp=0", r_res); else passed++;
        total++; if (r_id !== 1'b0) $display("FAIL rst_rr_id got=%0b exp=0", r_id); else passed++;
        total++; if (r_stall !== 4'd0) $display("FAIL rst_rr_stall got=%0d exp=0", r_stall); else passed++;
        total++; if (f_rvalid !== 1'b0) $display("FAIL rst_fx_valid got=%0b exp=0", f_rvalid); else passed++;
        total++; if (f_res !== 32'd0) $display("FAIL rst_fx_result got=%0h exp=0", f_res); else passed++;
        total++; if (f_stall !== 4'd0) $display("FAIL rst_fx_stall got=%0d exp=0", f_stall); else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_rr_contention();
        r_v0 = 1; r_op0 = ALU_SUB; r_a0 = 32'd10;  r_b0 = 32'd3;
        r_v1 = 1; r_op1 = ALU_XOR; r_a1 = 32'hF0;  r_b1 = 32'hFF;
        r_rready = 1;
        #1;
        total++; if ({r_rdy1, r_rdy0} !== 2'b01) $display("FAIL rr_first_ready got=%b exp=01", {r_rdy1, r_rdy0}); else passed++;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (r_id !== req_id_t'(i % 2)) $display("FAIL rr_id[%0d] got=%0b exp=%0d", i, r_id, i % 2); else passed++;
            total++; if (r_res !== ((i % 2) ? 32'h0F : 32'd7)) $display("FAIL rr_result[%0d] got=%0h", i, r_res); else passed++;
            total++; if (r_rvalid !== 1'b1) $display("FAIL rr_valid[%0d] got=%0b exp=1", i, r_rvalid); else passed++;
        end
    endtask

    task automatic test_backpressure();
        // last grant was requester 1, so requester 0 wins here
        tick();
        total++; if (r_res !== 32'd7 || r_id !== 1'b0) $display("FAIL bp_load got=%0h/%0b exp=7/0", r_res, r_id); else passed++;
        r_rready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if ({r_rdy1, r_rdy0} !== 2'b00) $display("FAIL bp_ready[%0d] got=%b exp=00", i, {r_rdy1, r_rdy0}); else passed++;
            tick();
            total++; if (r_res !== 32'd7 || r_id !== 1'b0 || r_rvalid !== 1'b1)
                $display("FAIL bp_hold[%0d] got=%0h/%0b/%0b exp=7/0/1", i, r_res, r_id, r_rvalid); else passed++;
        end
        r_rready = 1;
        #1;
        total++; if ({r_rdy1, r_rdy0} !== 2'b10) $display("FAIL bp_release_ready got=%b exp=10", {r_rdy1, r_rdy0}); else passed++;
        tick();
        total++; if (r_res !== 32'h0F || r_id !== 1'b1) $display("FAIL bp_next got=%0h/%0b exp=f/1", r_res, r_id); else passed++;
        r_v0 = 0; r_v1 = 0;
        tick();
        total++; if (r_rvalid !== 1'b0) $display("FAIL bp_drain got=%0b exp=0", r_rvalid); else passed++;
    endtask

    task automatic test_compare();
        r_v1 = 1; r_op1 = ALU_SLT; r_a1 = 32'hFFFF_FFFF; r_b1 = 32'd1;
        tick();
        total++; if (r_res !== 32'd1 || r_id !== 1'b1) $display("FAIL slt got=%0h/%0b exp=1/1", r_res, r_id); else passed++;
        r_op1 = ALU_SLTU;
        tick();
        total++; if (r_res !== 32'd0 || r_id !== 1'b1) $display("FAIL sltu got=%0h/%0b exp=0/1", r_res, r_id); else passed++;
        r_v1 = 0;
        tick();
    endtask

    task automatic test_single();
        r_v0 = 1; r_op0 = ALU_ADD; r_a0 = 32'd5; r_b0 = 32'd7;
        #1;
        total++; if ({r_rdy1, r_rdy0} !== 2'b01) $display("FAIL single_ready got=%b exp=01", {r_rdy1, r_rdy0}); else passed++;
        tick();
        total++; if (r_rvalid !== 1'b1 || r_res !== 32'd12 || r_id !== 1'b0)
            $display("FAIL single_result got=%0b/%0d/%0b exp=1/12/0", r_rvalid, r_res, r_id); else passed++;
        r_v0 = 0;
        tick();
        total++; if (r_rvalid !== 1'b0) $display("FAIL single_drain got=%0b exp=0", r_rvalid); else passed++;
    endtask

    task automatic test_fixed();
        logic   exp_id;
        logic [3:0] exp_cnt;
        f_v0 = 1; f_op0 = ALU_ADD; f_a0 = 32'd1; f_b0 = 32'd1;
        f_v1 = 1; f_op1 = ALU_SUB; f_a1 = 32'd9; f_b1 = 32'd4;
        f_rready = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_id  = ((i % 4) == 3);
            exp_cnt = exp_id ? 4'd0 : 4'((i % 4) + 1);
            total++; if (f_id !== exp_id) $display("FAIL fx_id[%0d] got=%0b exp=%0b", i, f_id, exp_id); else passed++;
            total++; if (f_res !== (exp_id ? 32'd5 : 32'd2)) $display("FAIL fx_result[%0d] got=%0d", i, f_res); else passed++;
            total++; if (f_stall !== exp_cnt) $display("FAIL fx_stall[%0d] got=%0d exp=%0d", i, f_stall, exp_cnt); else passed++;
        end
    endtask

    task automatic test_reset_mid();
        r_v0 = 1; r_op0 = ALU_ADD; r_a0 = 32'd5; r_b0 = 32'd7;
        tick();
        tick();
        total++; if (f_stall !== 4'd2 || f_rvalid !== 1'b1) $display("FAIL mid_pre got=%0d/%0b exp=2/1", f_stall, f_rvalid); else passed++;
        f_rready = 0;
        tick();
        total++; if (f_stall !== 4'd2) $display("FAIL fx_stall_hold got=%0d exp=2", f_stall); else passed++;
        f_rready = 1;
        r_v1 = 1;
        rst_n = 0;
        tick();
        rst_n = 1;
        total++; if (r_rvalid !== 1'b0 || f_rvalid !== 1'b0) $display("FAIL mid_valid got=%0b/%0b exp=0/0", r_rvalid, f_rvalid); else passed++;
        total++; if (f_stall !== 4'd0) $display("FAIL mid_stall got=%0d exp=0", f_stall); else passed++;
        #1;
        total++; if ({r_rdy1, r_rdy0} !== 2'b01) $display("FAIL mid_rr_ready got=%b exp=01", {r_rdy1, r_rdy0}); else passed++;
        total++; if ({f_rdy1, f_rdy0} !== 2'b01) $display("FAIL mid_fx_ready got=%b exp=01", {f_rdy1, f_rdy0}); else passed++;
        tick();
        total++; if (r_id !== 1'b0 || f_id !== 1'b0) $display("FAIL mid_first_id got=%0b/%0b exp=0/0", r_id, f_id); else passed++;
        tick();
        total++; if (r_id !== 1'b1) $display("FAIL mid_rr_second_id got=%0b exp=1", r_id); else passed++;
        r_v0 = 0; r_v1 = 0; f_v0 = 0; f_v1 = 0;
        tick();
    endtask

    initial begin
        #50000;
        $display("FAIL timeout reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_rr_contention();
        test_backpressure();
        test_compare();
        test_single();
        test_fixed();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
